// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared constants for the JESD204 TPL DAC channel: sequencer state codes and data-select codes.
// Latency: none (constants and a pure helper function).
// Backpressure: none.
package ad_ip_jesd204_tpl_dac_pkg;

    // Sequencer state encodings
    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_ARM   = 2'd1;
    localparam logic [1:0] SEQ_APPLY = 2'd2;
    localparam logic [1:0] SEQ_DWELL = 2'd3;

    // Channel data-select codes
    localparam logic [3:0] DAC_SEL_DDS  = 4'h0;
    localparam logic [3:0] DAC_SEL_PAT  = 4'h1;
    localparam logic [3:0] DAC_SEL_DMA  = 4'h2;
    localparam logic [3:0] DAC_SEL_ZERO = 4'h3;
    localparam logic [3:0] DAC_SEL_PN7  = 4'h6;
    localparam logic [3:0] DAC_SEL_PN15 = 4'h7;

    // A last-entry index beyond the table is pulled back to the final entry.
    function automatic logic [2:0] seq_clamp_last(input logic [2:0] last, input int num_entries);
        if (int'(last) >= num_entries) begin
            return 3'(num_entries - 1);
        end
        return last;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_seq_dwell.sv
// Dwell down-counter: loads a count and steps toward zero, flagging terminal count.
// Latency: load visible one clk after the load cycle; tc is combinational from the count register.
// Backpressure: none; en gates decrement, the counter parks at zero.
// Ports: clk, rst (async, active-high), load/load_val, en, tc (count == 0).
module ad_ip_jesd204_tpl_dac_seq_dwell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_seq.sv
// DAC channel data-select sequencer: steps through a table of (select, dwell) entries per run.
// Latency: one clk from accepted start / trigger edge to the first select + sync pulse.
// Backpressure: none; start while busy is ignored, stop aborts any run.
// Ports: clk, rst (async active-high); cfg_* table and run options; start/stop requests;
//        ext_trig (rising edge used while armed); dac_data_sel/dac_data_sync to the channel mux;
//        busy, done pulse, entry_idx and pass_count status.
module ad_ip_jesd204_tpl_dac_seq
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int         NUM_ENTRIES = 4,
    parameter int         DWELL_WIDTH = 16,
    parameter logic [3:0] IDLE_SEL    = DAC_SEL_ZERO
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [4*NUM_ENTRIES-1:0]          cfg_sel,
    input  logic [DWELL_WIDTH*NUM_ENTRIES-1:0] cfg_dwell,
    input  logic [2:0]                        cfg_last,
    input  logic                              cfg_loop,
    input  logic                              cfg_trig_en,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              ext_trig,
    output logic [3:0]                        dac_data_sel,
    output logic                              dac_data_sync,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        entry_idx,
    output logic [15:0]                       pass_count
);

    logic [1:0]                         state;
    logic                               trig_prev;

    // Run configuration captured on the accepted start
    logic [4*NUM_ENTRIES-1:0]           sel_q;
    logic [DWELL_WIDTH*NUM_ENTRIES-1:0] dwell_q;
    logic [2:0]                         last_q;
    logic                               loop_q;

    logic                               start_ok;
    logic                               trig_edge;
    logic                               in_entry;
    logic                               entry_end;
    logic                               at_last;
    logic                               pass_inc;
    logic [2:0]                         next_idx;
    logic                               apply;
    logic [2:0]                         apply_idx;
    logic [3:0]                         apply_sel;
    logic [DWELL_WIDTH-1:0]             apply_dwell;
    logic                               dwell_tc;

    always_comb begin
        start_ok    = start && !stop && (state == SEQ_IDLE);
        trig_edge   = ext_trig && !trig_prev;
        in_entry    = (state == SEQ_APPLY) || (state == SEQ_DWELL);
        entry_end   = in_entry && dwell_tc;
        at_last     = (entry_idx == last_q);
        pass_inc    = entry_end && at_last && !stop;
        next_idx    = at_last ? 3'd0 : entry_idx + 3'd1;
        apply       = 1'b0;
        apply_idx   = 3'd0;
        apply_sel   = sel_q[3:0];
        apply_dwell = dwell_q[DWELL_WIDTH-1:0];
        if (start_ok && !cfg_trig_en) begin
            // Untriggered start applies entry 0 straight from the live config,
            // which is the same value being snapshotted this cycle.
            apply       = 1'b1;
            apply_sel   = cfg_sel[3:0];
            apply_dwell = cfg_dwell[DWELL_WIDTH-1:0];
        end else if (!stop && (state == SEQ_ARM) && trig_edge) begin
            apply = 1'b1;
        end else if (!stop && entry_end && (!at_last || loop_q)) begin
            // Back-to-back entries: the next entry loads on the terminal-count cycle, no gap.
            apply       = 1'b1;
            apply_idx   = next_idx;
            apply_sel   = sel_q[4*int'(next_idx) +: 4];
            apply_dwell = dwell_q[DWELL_WIDTH*int'(next_idx) +: DWELL_WIDTH];
        end
    end

    ad_ip_jesd204_tpl_dac_seq_dwell #(
        .WIDTH (DWELL_WIDTH)
    ) i_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (apply),
        .load_val (apply_dwell),
        .en       (in_entry),
        .tc       (dwell_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEQ_IDLE;
            trig_prev     <= 1'b0;
            dac_data_sel  <= IDLE_SEL;
            dac_data_sync <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            entry_idx     <= 3'd0;
            pass_count    <= 16'd0;
            sel_q         <= '0;
            dwell_q       <= '0;
            last_q        <= 3'd0;
            loop_q        <= 1'b0;
        end else begin
            trig_prev     <= ext_trig;
            dac_data_sync <= 1'b0;
            done          <= 1'b0;

            if (start_ok) begin
                sel_q   <= cfg_sel;
                dwell_q <= cfg_dwell;
                last_q  <= seq_clamp_last(cfg_last, NUM_ENTRIES);
                loop_q  <= cfg_loop;
            end

            if (start_ok) begin
                pass_count <= 16'd0;
            end else if (pass_inc && (pass_count != 16'hFFFF)) begin
                pass_count <= pass_count + 16'd1;
            end

            if (stop && (state != SEQ_IDLE)) begin
                state        <= SEQ_IDLE;
                dac_data_sel <= IDLE_SEL;
                busy         <= 1'b0;
            end else if (apply) begin
                state         <= SEQ_APPLY;
                dac_data_sel  <= apply_sel;
                dac_data_sync <= 1'b1;
                entry_idx     <= apply_idx;
                busy          <= 1'b1;
            end else if (start_ok) begin
                state <= SEQ_ARM;
                busy  <= 1'b1;
            end else if (entry_end) begin
                // Only reachable on the last entry of a non-looping run
                state        <= SEQ_IDLE;
                dac_data_sel <= IDLE_SEL;
                busy         <= 1'b0;
                done         <= 1'b1;
            end else if (state == SEQ_APPLY) begin
                state <= SEQ_DWELL;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_seq.sv
// Bench for the DAC data-select sequencer: elapsed-time reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_ad_ip_jesd204_tpl_dac_seq;

    localparam int         N    = 4;
    localparam int         DW   = 16;
    localparam logic [3:0] ISEL = 4'h3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*N-1:0]  cfg_sel = '0;
    logic [DW*N-1:0] cfg_dwell = '0;
    logic [2:0]      cfg_last = 3'd0;
    logic            cfg_loop = 1'b0;
    logic            cfg_trig_en = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            ext_trig = 1'b0;
    logic [3:0]      dac_data_sel;
    logic            dac_data_sync;
    logic            busy;
    logic            done;
    logic [2:0]      entry_idx;
    logic [15:0]     pass_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ad_ip_jesd204_tpl_dac_seq #(
        .NUM_ENTRIES (N),
        .DWELL_WIDTH (DW),
        .IDLE_SEL    (ISEL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_sel       (cfg_sel),
        .cfg_dwell     (cfg_dwell),
        .cfg_last      (cfg_last),
        .cfg_loop      (cfg_loop),
        .cfg_trig_en   (cfg_trig_en),
        .start         (start),
        .stop          (stop),
        .ext_trig      (ext_trig),
        .dac_data_sel  (dac_data_sel),
        .dac_data_sync (dac_data_sync),
        .busy          (busy),
        .done          (done),
        .entry_idx     (entry_idx),
        .pass_count    (pass_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is described by its start period t0; outputs at period P follow from
    // k = P - t0 against the cumulative entry lengths of the snapshotted table.
    int         mode = 0;            // 0 idle, 1 armed, 2 running
    int         cyc = 0;
    int         t0 = 0;
    int         plen = 0;
    int         m_last = 0;
    bit         m_loop = 1'b0;
    int         m_sel [N];
    int         m_dw  [N];
    bit         prev_trig = 1'b0;
    int         k, off, acc;
    logic [3:0] e_sel  = ISEL;
    logic       e_sync = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    logic [2:0] e_idx  = 3'd0;
    logic [15:0] e_pass = 16'd0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mode = 0; prev_trig = 1'b0;
                e_sel = ISEL; e_sync = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                e_idx = 3'd0; e_pass = 16'd0;
            end else begin
                cyc++;
                e_sync = 1'b0;
                e_done = 1'b0;
                if (stop && mode != 0) begin
                    mode = 0;
                end else if (start && !stop && mode == 0) begin
                    for (int i = 0; i < N; i++) begin
                        m_sel[i] = int'(cfg_sel[4*i +: 4]);
                        m_dw[i]  = int'(cfg_dwell[DW*i +: DW]);
                    end
                    m_last = (int'(cfg_last) >= N) ? N - 1 : int'(cfg_last);
                    m_loop = cfg_loop;
                    plen = 0;
                    for (int i = 0; i <= m_last; i++) plen += m_dw[i] + 1;
                    e_pass = 16'd0;
                    if (cfg_trig_en) mode = 1;
                    else begin mode = 2; t0 = cyc; end
                end else if (mode == 1 && ext_trig && !prev_trig) begin
                    mode = 2; t0 = cyc;
                end
                prev_trig = ext_trig;
                if (mode == 2) begin
                    k = cyc - t0;
                    if (!m_loop && k == plen) begin
                        mode = 0; e_done = 1'b1; e_pass = 16'd1;
                    end else begin
                        off = k % plen;
                        acc = 0;
                        e_pass = (k / plen > 65535) ? 16'hFFFF : 16'(k / plen);
                        for (int i = 0; i <= m_last; i++) begin
                            if (off >= acc && off < acc + m_dw[i] + 1) begin
                                e_sel  = 4'(m_sel[i]);
                                e_idx  = 3'(i);
                                e_sync = (off == acc);
                            end
                            acc += m_dw[i] + 1;
                        end
                    end
                end
                if (mode == 0) e_sel = ISEL;
                e_busy = (mode != 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("sel",  32'(dac_data_sel),  32'(e_sel));
                chk("sync", 32'(dac_data_sync), 32'(e_sync));
                chk("busy", 32'(busy),          32'(e_busy));
                chk("done", 32'(done),          32'(e_done));
                chk("idx",  32'(entry_idx),     32'(e_idx));
                chk("pass", 32'(pass_count),    32'(e_pass));
            end
        end
    end

    // ---------------- capture helpers ----------------
    logic [3:0]  c_sel  [64];
    logic        c_sync [64];
    logic        c_done [64];
    logic        c_busy [64];
    logic [2:0]  c_idx  [64];
    logic [15:0] c_pass [64];
    int          exp_t1 [11] = '{1, 1, 1, 1, 7, 2, 2, 2, 2, 2, 2};

    task automatic smp(input int i);
        c_sel[i]  = dac_data_sel;
        c_sync[i] = dac_data_sync;
        c_done[i] = done;
        c_busy[i] = busy;
        c_idx[i]  = entry_idx;
        c_pass[i] = pass_count;
    endtask

    task automatic set_tbl1(input bit loop);
        cfg_sel     = 16'h0271;
        cfg_dwell   = {16'd0, 16'd5, 16'd0, 16'd3};
        cfg_last    = 3'd2;
        cfg_loop    = loop;
        cfg_trig_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    function automatic int count_sync(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(c_sync[i]);
        return c;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(c_done[i]);
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sel",  32'(dac_data_sel),  32'h3);
        chk("rst_sync", 32'(dac_data_sync), 32'h0);
        chk("rst_busy", 32'(busy),          32'h0);
        chk("rst_done", 32'(done),          32'h0);
        chk("rst_idx",  32'(entry_idx),     32'h0);
        chk("rst_pass", 32'(pass_count),    32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single pass through {1:3, 7:0, 2:5}
        set_tbl1(1'b0);
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
        end
        for (int i = 0; i < 11; i++) chk("t1_sel", 32'(c_sel[i]), 32'(exp_t1[i]));
        chk("t1_sel_end", 32'(c_sel[11]), 32'h3);
        chk("t1_nsync", count_sync(13), 3);
        chk("t1_sync4", 32'(c_sync[4]), 1);
        chk("t1_sync5", 32'(c_sync[5]), 1);
        chk("t1_done11", 32'(c_done[11]), 1);
        chk("t1_ndone", count_done(13), 1);
        chk("t1_pass", 32'(c_pass[12]), 1);
        chk("t1_busy_end", 32'(c_busy[11]), 0);
        repeat (2) @(negedge clk);

        // Looping run, then stop
        set_tbl1(1'b1);
        pulse_start();
        for (int i = 0; i < 36; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
            stop = (i == 34);
        end
        stop = 1'b0;
        chk("t2_sel10", 32'(c_sel[10]), 2);
        chk("t2_sel11", 32'(c_sel[11]), 1);
        chk("t2_sync11", 32'(c_sync[11]), 1);
        chk("t2_pass32", 32'(c_pass[32]), 2);
        chk("t2_pass33", 32'(c_pass[33]), 3);
        chk("t2_ndone", count_done(36), 0);
        chk("t2_stop_sel", 32'(c_sel[35]), 3);
        chk("t2_stop_busy", 32'(c_busy[35]), 0);
        repeat (2) @(negedge clk);

        // Triggered start: trigger rises 10 cycles later and stays high 20 cycles
        set_tbl1(1'b0);
        cfg_trig_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
            ext_trig = (i >= 10 && i < 30);
        end
        ext_trig = 1'b0;
        cfg_trig_en = 1'b0;
        chk("t3_armed_busy", 32'(c_busy[10]), 1);
        chk("t3_armed_sel", 32'(c_sel[10]), 3);
        chk("t3_first_sel", 32'(c_sel[11]), 1);
        chk("t3_first_sync", 32'(c_sync[11]), 1);
        chk("t3_done22", 32'(c_done[22]), 1);
        chk("t3_nsync", count_sync(32), 3);
        chk("t3_idle_busy", 32'(c_busy[29]), 0);
        chk("t3_idle_sel", 32'(c_sel[30]), 3);
        repeat (2) @(negedge clk);

        // Stop inside the second entry
        cfg_sel   = 16'h0621;
        cfg_dwell = {16'd0, 16'd0, 16'd5, 16'd3};
        cfg_last  = 3'd2;
        cfg_loop  = 1'b0;
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
            stop = (i == 6);
        end
        stop = 1'b0;
        chk("t4_sel6", 32'(c_sel[6]), 2);
        chk("t4_idx6", 32'(c_idx[6]), 1);
        chk("t4_stop_sel", 32'(c_sel[7]), 3);
        chk("t4_stop_busy", 32'(c_busy[7]), 0);
        chk("t4_ndone", count_done(14), 0);
        // start and stop together in idle
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", 32'(busy), 0);
        chk("t4_ss_sel", 32'(dac_data_sel), 3);
        @(negedge clk);
        chk("t4_ss_busy2", 32'(busy), 0);

        // Asynchronous reset in the middle of a dwell on the second pass
        set_tbl1(1'b1);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
        end
        chk("t5_pre_pass", 32'(c_pass[16]), 1);
        chk("t5_pre_idx", 32'(c_idx[16]), 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst_sel",  32'(dac_data_sel),  32'h3);
        chk("t5_arst_sync", 32'(dac_data_sync), 32'h0);
        chk("t5_arst_busy", 32'(busy),          32'h0);
        chk("t5_arst_done", 32'(done),          32'h0);
        chk("t5_arst_idx",  32'(entry_idx),     32'h0);
        chk("t5_arst_pass", 32'(pass_count),    32'h0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_post_busy", 32'(busy), 0);

        // cfg_last beyond the table runs all four entries
        cfg_sel   = 16'h6271;
        cfg_dwell = {16'd1, 16'd5, 16'd0, 16'd3};
        cfg_last  = 3'd7;
        cfg_loop  = 1'b0;
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
        end
        chk("t5_e3_sel11", 32'(c_sel[11]), 6);
        chk("t5_e3_sync11", 32'(c_sync[11]), 1);
        chk("t5_e3_sel12", 32'(c_sel[12]), 6);
        chk("t5_e3_idx12", 32'(c_idx[12]), 3);
        chk("t5_e3_done13", 32'(c_done[13]), 1);
        chk("t5_e3_sel13", 32'(c_sel[13]), 3);
        repeat (2) @(negedge clk);

        // Config rewritten mid-run and a start while busy
        set_tbl1(1'b1);
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            smp(i);
            if (i == 2) begin
                cfg_dwell = '0;
                cfg_sel   = 16'hFFFF;
                cfg_last  = 3'd0;
            end
            start = (i == 15);
            stop  = (i == 22);
        end
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 22; i++) chk("t6_sel", 32'(c_sel[i]), 32'(exp_t1[i % 11]));
        chk("t6_pass17", 32'(c_pass[17]), 1);
        chk("t6_pass21", 32'(c_pass[21]), 1);
        chk("t6_pass22", 32'(c_pass[22]), 2);
        chk("t6_stop_busy", 32'(c_busy[23]), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_seq.md
AD_IP_JESD204_TPL_DAC_SEQ -- requirements
Module: ad_ip_jesd204_tpl_dac_seq

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: number of sequence table entries, 2..8.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of each entry dwell count.
REQ-003 SHALL have parameter IDLE_SEL, default 4'h3: data-select code driven while idle (zero output).
REQ-004 SHALL have port clk, input, 1: single clock; the block has one clock, the DAC channel clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port cfg_sel, input, 4*NUM_ENTRIES: per-entry data-select code, entry k at bits [4k+:4].
REQ-007 SHALL have port cfg_dwell, input, DWELL_WIDTH*NUM_ENTRIES: per-entry dwell, entry k at bits [DWELL_WIDTH*k+:DWELL_WIDTH].
REQ-008 SHALL have port cfg_last, input, 3: index of the last active entry; values >= NUM_ENTRIES are treated as NUM_ENTRIES-1.
REQ-009 SHALL have ports cfg_loop, input, 1 (repeat forever) and cfg_trig_en, input, 1 (wait for ext_trig before the first entry).
REQ-010 SHALL have ports start, input, 1 (single-cycle request) and stop, input, 1 (single-cycle abort).
REQ-011 SHALL have port ext_trig, input, 1: level input, already synchronous to clk; only its rising edge is used.
REQ-012 SHALL have port dac_data_sel, output, 4: data-select code for the channel mux.
REQ-013 SHALL have port dac_data_sync, output, 1: one-cycle pulse restarting the DDS and pattern phase.
REQ-014 SHALL have ports busy, output, 1; done, output, 1 (pulse); entry_idx, output, 3; pass_count, output, 16.

Function
REQ-015 SHALL implement states IDLE, ARM, APPLY, DWELL.
REQ-016 On start in IDLE: SHALL go to ARM if cfg_trig_en=1, else to APPLY; start in any other state SHALL be ignored.
REQ-017 SHALL snapshot cfg_sel, cfg_dwell, cfg_last and cfg_loop on the accepted start; config changes during a run SHALL have no effect.
REQ-018 ARM: SHALL detect the rising edge as ext_trig=1 with the registered previous value=0, then go to APPLY; ext_trig SHALL be ignored outside ARM.
REQ-019 APPLY (one cycle): dac_data_sel<=sel[idx], dac_data_sync<=1, entry_idx<=idx, dwell counter<=dwell[idx].
REQ-020 Each entry SHALL drive dac_data_sel for exactly dwell+1 cycles; dwell=0 gives one cycle, with sync high in the first cycle only.
REQ-021 At entry end with idx<last: SHALL set idx+1 and apply the next entry with no gap cycle.
REQ-022 At entry end with idx=last and loop=1: SHALL set idx=0, increment pass_count (saturating at 16'hFFFF) and apply entry 0 with no gap.
REQ-023 At entry end with idx=last and loop=0: SHALL increment pass_count, pulse done for 1 cycle, drive dac_data_sel=IDLE_SEL and go to IDLE.
REQ-024 stop in any non-IDLE state: SHALL go to IDLE next cycle with dac_data_sel=IDLE_SEL and no done pulse; stop and start in the same cycle SHALL resolve as stop wins.
REQ-025 All outputs SHALL be registered, with one-cycle latency from the sampled start or trigger edge to the first dac_data_sel/dac_data_sync change.
REQ-026 busy SHALL be 1 in every state except IDLE; pass_count SHALL clear on an accepted start.

Reset
REQ-027 While rst is asserted, SHALL force state=IDLE, dac_data_sel=IDLE_SEL, dac_data_sync=0, busy=0, done=0, entry_idx=0, pass_count=0 and the trigger history register=0.
REQ-028 Reset asserted mid-run SHALL abort immediately with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-029 SHALL place the state encodings and data-select constants (DDS 0, PAT 1, DMA 2, ZERO 3, PN7 6, PN15 7) in shared package ad_ip_jesd204_tpl_dac_pkg.
REQ-030 SHALL implement the dwell down-counter as one sub-module, ad_ip_jesd204_tpl_dac_seq_dwell, with load, terminal-count flag and an async reset.

Verification
REQ-031 SHALL verify: entries {1:3, 7:0, 2:5}, last=2, loop=0, start -> sel 1 for 4 cycles, 7 for 1, 2 for 6, then 3; three sync pulses; done on the 12th cycle after start; pass_count=1.
REQ-032 SHALL verify: same table with loop=1 -> sel 2 followed directly by 1 with no gap cycle; pass_count=3 after 33 cycles; no done pulse.
REQ-033 SHALL verify: cfg_trig_en=1, start, then ext_trig held high for 20 cycles after a 10-cycle delay -> first entry begins exactly 1 cycle after the edge, with no retrigger while high.
REQ-034 SHALL verify: stop during the second entry's dwell -> sel=3 next cycle, busy=0, no done; start and stop in the same cycle in IDLE -> remains IDLE.
REQ-035 SHALL verify: rst asserted mid-DWELL asynchronously -> all outputs at reset values before the next clk edge; cfg_last=7 with NUM_ENTRIES=4 -> 4 entries run.
REQ-036 SHALL verify: cfg_dwell rewritten mid-run -> current run timing unchanged; start while busy -> ignored, pass_count not cleared.
